uart_rx_frame_ctrl: RTL

//  Frame controller sitting directly behind the UART receiver. Consumes its byte stream (byte + 1-cycle done pulse).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_gap_timer.sv | 32 +++
 rtl/uart_rx_frame_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame-controller states, error codes
// and the default frame start marker.
package uart_pkg;

    typedef enum logic [2:0] {
        sIDLE = 3'd0,
        sCMD  = 3'd1,
        sLEN  = 3'd2,
        sDATA = 3'd3,
        sCHK  = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CHK  = 2'b10,
        ERR_TMO  = 2'b11
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts while enabled, clears on iClr, and pulses oExpire
// on the terminal count unless a clear arrives in the same cycle.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CLKS = 32550
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iClr,
    output logic oExpire
);

    localparam int unsigned W = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] r_cnt;
    logic         w_term;

    assign w_term  = iEn && !iClr && (r_cnt == TERM);
    assign oExpire = w_term;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_cnt <= '0;
        end else if (!iEn || iClr || w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: parses SYNC/CMD/LEN/payload/CHK,
// streams payload bytes and flags each frame good, bad or timed out.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 125_000_000,
    parameter int unsigned BAUD_RATE    = 115_200,
    parameter int unsigned TIMEOUT_BITS = 30,
    parameter int unsigned TIMEOUT_CLKS = CLK_FREQ / BAUD_RATE * TIMEOUT_BITS,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iRxByte,
    input  logic       iRxDone,
    output logic [7:0] oCmd,
    output logic [7:0] oLen,
    output logic [7:0] oDataByte,
    output logic [7:0] oDataIdx,
    output logic       oDataValid,
    output logic       oFrameOk,
    output logic       oFrameErr,
    output logic [1:0] oErrCode,
    output logic       oBusy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    rx_state_t r_state, w_state;
    err_code_t r_err_code, w_err_code;
    logic [7:0] r_cmd, w_cmd, r_len, w_len, r_chk, w_chk, r_cnt, w_cnt;
    logic [7:0] r_data_byte, w_data_byte, r_data_idx, w_data_idx;
    logic       r_data_valid, w_data_valid, r_ok, w_ok, r_err, w_err, r_busy;
    logic       w_expire;

    uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap_timer (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (r_state != sIDLE),
        .iClr    (iRxDone),
        .oExpire (w_expire)
    );

    always_comb begin
        w_state      = r_state;
        w_cmd        = r_cmd;
        w_len        = r_len;
        w_chk        = r_chk;
        w_cnt        = r_cnt;
        w_data_byte  = r_data_byte;
        w_data_idx   = r_data_idx;
        w_data_valid = 1'b0;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_err_code   = r_err_code;
        case (r_state)
            sIDLE: if (iRxDone && iRxByte == SYNC_BYTE) w_state = sCMD;
            sCMD: if (iRxDone) begin
                w_cmd   = iRxByte;
                w_chk   = iRxByte;
                w_state = sLEN;
            end
            sLEN: if (iRxDone) begin
                w_len = iRxByte;
                w_chk = r_chk ^ iRxByte;
                if (iRxByte > MAX_LEN_B) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_LEN;
                    w_state    = sIDLE;
                end else if (iRxByte == '0) begin
                    w_state = sCHK;
                end else begin
                    w_cnt   = '0;
                    w_state = sDATA;
                end
            end
            sDATA: if (iRxDone) begin
                w_data_byte  = iRxByte;
                w_data_idx   = r_cnt;
                w_data_valid = 1'b1;
                w_chk        = r_chk ^ iRxByte;
                w_cnt        = r_cnt + 8'd1;
                if (r_cnt == r_len - 8'd1) w_state = sCHK;
            end
            sCHK: if (iRxDone) begin
                if (iRxByte == r_chk) begin
                    w_ok = 1'b1;
                end else begin
                    w_err      = 1'b1;
                    w_err_code = ERR_CHK;
                end
                w_state = sIDLE;
            end
            default: w_state = sIDLE;
        endcase
        // Expiry never coincides with iRxDone, so it cannot clobber a byte's update.
        if (w_expire) begin
            w_err      = 1'b1;
            w_err_code = ERR_TMO;
            w_state    = sIDLE;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state      <= sIDLE;
            r_cmd        <= '0;
            r_len        <= '0;
            r_chk        <= '0;
            r_cnt        <= '0;
            r_data_byte  <= '0;
            r_data_idx   <= '0;
            r_data_valid <= 1'b0;
            r_ok         <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cmd        <= w_cmd;
            r_len        <= w_len;
            r_chk        <= w_chk;
            r_cnt        <= w_cnt;
            r_data_byte  <= w_data_byte;
            r_data_idx   <= w_data_idx;
            r_data_valid <= w_data_valid;
            r_ok         <= w_ok;
            r_err        <= w_err;
            r_err_code   <= w_err_code;
            r_busy       <= (w_state != sIDLE);
        end
    end

    assign oCmd       = r_cmd;
    assign oLen       = r_len;
    assign oDataByte  = r_data_byte;
    assign oDataIdx   = r_data_idx;
    assign oDataValid = r_data_valid;
    assign oFrameOk   = r_ok;
    assign oFrameErr  = r_err;
    assign oErrCode   = r_err_code;
    assign oBusy      = r_busy;

endmodule
